// File: rtl/lc3_mem_responder_if.sv
// Bus between the LC-3 control/datapath (master) and the memory responder (slave).
// Carries the MAR/MDR request side, the switch input and the responder's outputs.
interface lc3_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] MAR;
   logic [DATA_W-1:0] Data_to_mem;
   logic              Mem_OE;
   logic              Mem_WE;
   logic [DATA_W-1:0] Switches;
   logic [DATA_W-1:0] Data_from_mem;
   logic              Mem_Ready;
   logic [DATA_W-1:0] Hex_out;
   logic              Err;

   modport master (output MAR, Data_to_mem, Mem_OE, Mem_WE, Switches,
                   input  Data_from_mem, Mem_Ready, Hex_out, Err);
   modport slave  (input  MAR, Data_to_mem, Mem_OE, Mem_WE, Switches,
                   output Data_from_mem, Mem_Ready, Hex_out, Err);
endinterface

// File: rtl/lc3_mem_responder.sv
// On-chip memory responder for the LC-3 datapath: wait-state read/write handshake
// against a word array, with IO_ADDR mapped to switches (read) and a hex register (write).
module lc3_mem_responder #(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 16,
   parameter int                DEPTH     = 1024,
   parameter int                READ_LAT  = 2,
   parameter int                WRITE_LAT = 3,
   parameter logic [ADDR_W-1:0] IO_ADDR   = 16'hFFFF
) (
   input logic               Clk,
   input logic               Reset,
   lc3_mem_responder_if.slave bus
);
   localparam int                IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [2:0]        RL_M2   = 3'(READ_LAT - 2);
   localparam logic [2:0]        WL_M1   = 3'(WRITE_LAT - 1);
   localparam logic [2:0]        WL_M2   = 3'(WRITE_LAT - 2);

   typedef enum logic [2:0] {IDLE, RD, RD_HOLD, WR, WR_DONE} state_t;

   state_t            state;
   logic [2:0]        Cnt;
   logic [ADDR_W-1:0] Addr_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              start, err_c, load_c, commit_c;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] rd_val;

   // start: this cycle is cycle 1 of a (possibly restarted) access, or an idle cycle.
   always_comb begin
      start = 1'b0;
      err_c = 1'b0;
      case (state)
         IDLE: start = 1'b1;
         RD: begin
            if (bus.Mem_WE) err_c = 1'b1;
            else if (bus.Mem_OE && bus.MAR != Addr_q) begin err_c = 1'b1; start = 1'b1; end
         end
         RD_HOLD: begin
            if (bus.Mem_OE && bus.Mem_WE) err_c = 1'b1;
            else if (!bus.Mem_OE) start = 1'b1;
            else if (bus.MAR != Addr_q) begin err_c = 1'b1; start = 1'b1; end
         end
         WR: begin
            if (bus.Mem_OE || !bus.Mem_WE) err_c = 1'b1;
            else if (bus.MAR != Addr_q) begin err_c = 1'b1; start = 1'b1; end
         end
         WR_DONE: begin
            if (bus.Mem_OE && bus.Mem_WE) err_c = 1'b1;
            else if (!bus.Mem_WE) start = 1'b1;
         end
         default: start = 1'b1;
      endcase
   end

   always_comb begin
      acc_addr = start ? bus.MAR : Addr_q;
      load_c   = 1'b0;
      commit_c = 1'b0;
      if (start) begin
         load_c   = bus.Mem_OE && !bus.Mem_WE && (READ_LAT == 2);
         commit_c = bus.Mem_WE && !bus.Mem_OE && (WRITE_LAT == 1);
      end else if (!err_c) begin
         load_c   = (state == RD) && bus.Mem_OE && (Cnt == RL_M2);
         commit_c = (state == WR) && (Cnt == WL_M1);
      end
      if (acc_addr == IO_ADDR)     rd_val = bus.Switches;
      else if (acc_addr < DEPTH_A) rd_val = mem[acc_addr[IDX_W-1:0]];
      else                         rd_val = '0;
   end

   // Gated by Reset so an assertion on the would-be commit edge suppresses the write.
   always_ff @(posedge Clk) begin
      if (!Reset && commit_c && acc_addr != IO_ADDR && acc_addr < DEPTH_A)
         mem[acc_addr[IDX_W-1:0]] <= bus.Data_to_mem;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state             <= IDLE;
         Cnt               <= '0;
         Addr_q            <= '0;
         bus.Data_from_mem <= '0;
         bus.Mem_Ready     <= 1'b0;
         bus.Hex_out       <= '0;
         bus.Err           <= 1'b0;
      end else begin
         bus.Err <= err_c || (start && bus.Mem_OE && bus.Mem_WE);
         if (load_c) bus.Data_from_mem <= rd_val;
         if (commit_c && acc_addr == IO_ADDR) bus.Hex_out <= bus.Data_to_mem;
         if (start) begin
            if (bus.Mem_OE ^ bus.Mem_WE) begin
               Addr_q <= bus.MAR;
               Cnt    <= 3'd1;
            end else begin
               Cnt    <= '0;
            end
            if (bus.Mem_OE && !bus.Mem_WE) begin
               state         <= load_c ? RD_HOLD : RD;
               bus.Mem_Ready <= load_c;
            end else if (bus.Mem_WE && !bus.Mem_OE) begin
               state         <= commit_c ? WR_DONE : WR;
               bus.Mem_Ready <= commit_c || (WRITE_LAT == 2);
            end else begin
               state         <= IDLE;
               bus.Mem_Ready <= 1'b0;
            end
         end else if (err_c) begin
            state         <= IDLE;
            Cnt           <= '0;
            bus.Mem_Ready <= 1'b0;
         end else begin
            case (state)
               RD: begin
                  if (!bus.Mem_OE) begin
                     state         <= IDLE;
                     Cnt           <= '0;
                     bus.Mem_Ready <= 1'b0;
                  end else if (load_c) begin
                     state         <= RD_HOLD;
                     bus.Mem_Ready <= 1'b1;
                  end else begin
                     Cnt           <= Cnt + 3'd1;
                     bus.Mem_Ready <= 1'b0;
                  end
               end
               RD_HOLD: bus.Mem_Ready <= 1'b1;
               WR: begin
                  if (commit_c) begin
                     state         <= WR_DONE;
                     bus.Mem_Ready <= 1'b0;
                  end else begin
                     Cnt           <= Cnt + 3'd1;
                     bus.Mem_Ready <= (Cnt == WL_M2);
                  end
               end
               WR_DONE: bus.Mem_Ready <= 1'b0;
               default: begin
                  state         <= IDLE;
                  bus.Mem_Ready <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: each step drives one cycle of inputs and
// checks the registered outputs right after the edge that ends that cycle.
module tb_lc3_mem_responder;
   logic Clk, Reset;
   lc3_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   lc3_mem_responder dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst, oe, we;
      logic [15:0] mar, din;
      logic [15:0] e_dout;
      logic        e_rdy;
      logic [15:0] e_hex;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic rst, oe, we, input logic [15:0] mar, din,
                      input logic [15:0] e_dout, input logic e_rdy,
                      input logic [15:0] e_hex, input logic e_err);
      vec_t v;
      v = '{rst, oe, we, mar, din, e_dout, e_rdy, e_hex, e_err};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [15:0] act, exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input string tag, input vec_t v);
      @(negedge Clk);
      Reset           = v.rst;
      bus.Mem_OE      = v.oe;
      bus.Mem_WE      = v.we;
      bus.MAR         = v.mar;
      bus.Data_to_mem = v.din;
      @(posedge Clk);
      #1;
      chk({tag, " dout"},  bus.Data_from_mem,   v.e_dout);
      chk({tag, " ready"}, 16'(bus.Mem_Ready),  16'(v.e_rdy));
      chk({tag, " hex"},   bus.Hex_out,         v.e_hex);
      chk({tag, " err"},   16'(bus.Err),        16'(v.e_err));
   endtask

   task automatic hs(input string tag, input logic rst, oe, we, input logic [15:0] mar, din,
                     input logic [15:0] e_dout, input logic e_rdy,
                     input logic [15:0] e_hex, input logic e_err);
      vec_t v;
      v = '{rst, oe, we, mar, din, e_dout, e_rdy, e_hex, e_err};
      step(tag, v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      Reset = 1'b1;
      bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
      bus.MAR = '0; bus.Data_to_mem = '0; bus.Switches = 16'h5A5A;

      //  rst oe we  mar       din        dout      rdy hex       err
      add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0);  // reset state
      // preloads: 0x0010=1234, 0x0030=C3C3, 0x03FF=7777, 0x0000=0F0F
      add(0, 0, 1, 16'h0010, 16'h1234, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h0010, 16'h1234, 16'h0000, 1, 16'h0000, 0);
      add(0, 0, 1, 16'h0010, 16'h1234, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h0030, 16'hC3C3, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h0030, 16'hC3C3, 16'h0000, 1, 16'h0000, 0);
      add(0, 0, 1, 16'h0030, 16'hC3C3, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 0, 16'h0030, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h03FF, 16'h7777, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h03FF, 16'h7777, 16'h0000, 1, 16'h0000, 0);
      add(0, 0, 1, 16'h03FF, 16'h7777, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 0, 16'h03FF, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h0000, 16'h0F0F, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h0000, 16'h0F0F, 16'h0000, 1, 16'h0000, 0);
      add(0, 0, 1, 16'h0000, 16'h0F0F, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      // read 0x0010, OE held 3 cycles
      add(0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0000, 0);
      add(0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0000, 0);
      add(0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0000, 0);
      add(0, 0, 0, 16'h0010, 16'h0000, 16'h1234, 0, 16'h0000, 0);
      // write 0x0020, data changes to BEEF before the commit edge, WE held long
      add(0, 0, 1, 16'h0020, 16'h1111, 16'h1234, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h0020, 16'h1111, 16'h1234, 1, 16'h0000, 0);
      add(0, 0, 1, 16'h0020, 16'hBEEF, 16'h1234, 0, 16'h0000, 0);
      add(0, 0, 1, 16'h0020, 16'h2222, 16'h1234, 0, 16'h0000, 0);
      add(0, 1, 0, 16'h0020, 16'h0000, 16'hBEEF, 1, 16'h0000, 0);  // back-to-back read
      add(0, 0, 0, 16'h0020, 16'h0000, 16'hBEEF, 0, 16'h0000, 0);
      // I/O write and read
      add(0, 0, 1, 16'hFFFF, 16'h00A5, 16'hBEEF, 0, 16'h0000, 0);
      add(0, 0, 1, 16'hFFFF, 16'h00A5, 16'hBEEF, 1, 16'h0000, 0);
      add(0, 0, 1, 16'hFFFF, 16'h00A5, 16'hBEEF, 0, 16'h00A5, 0);
      add(0, 0, 0, 16'hFFFF, 16'h0000, 16'hBEEF, 0, 16'h00A5, 0);
      add(0, 1, 0, 16'hFFFF, 16'h0000, 16'h5A5A, 1, 16'h00A5, 0);
      add(0, 0, 0, 16'hFFFF, 16'h0000, 16'h5A5A, 0, 16'h00A5, 0);
      add(0, 1, 0, 16'h03FF, 16'h0000, 16'h7777, 1, 16'h00A5, 0);  // no alias of I/O write
      add(0, 0, 0, 16'h03FF, 16'h0000, 16'h7777, 0, 16'h00A5, 0);
      // short write to 0x0030
      add(0, 0, 1, 16'h0030, 16'h0BAD, 16'h7777, 0, 16'h00A5, 0);
      add(0, 0, 1, 16'h0030, 16'h0BAD, 16'h7777, 1, 16'h00A5, 0);
      add(0, 0, 0, 16'h0030, 16'h0BAD, 16'h7777, 0, 16'h00A5, 1);
      add(0, 0, 0, 16'h0030, 16'h0000, 16'h7777, 0, 16'h00A5, 0);
      add(0, 1, 0, 16'h0030, 16'h0000, 16'hC3C3, 1, 16'h00A5, 0);
      add(0, 0, 0, 16'h0030, 16'h0000, 16'hC3C3, 0, 16'h00A5, 0);
      // OE and WE together on the I/O address
      add(0, 1, 1, 16'hFFFF, 16'hDEAD, 16'hC3C3, 0, 16'h00A5, 1);
      add(0, 0, 0, 16'hFFFF, 16'h0000, 16'hC3C3, 0, 16'h00A5, 0);
      // out-of-range read and write
      add(0, 1, 0, 16'h2000, 16'h0000, 16'h0000, 1, 16'h00A5, 0);
      add(0, 0, 0, 16'h2000, 16'h0000, 16'h0000, 0, 16'h00A5, 0);
      add(0, 0, 1, 16'h2000, 16'h9999, 16'h0000, 0, 16'h00A5, 0);
      add(0, 0, 1, 16'h2000, 16'h9999, 16'h0000, 1, 16'h00A5, 0);
      add(0, 0, 1, 16'h2000, 16'h9999, 16'h0000, 0, 16'h00A5, 0);
      add(0, 0, 0, 16'h2000, 16'h0000, 16'h0000, 0, 16'h00A5, 0);
      add(0, 1, 0, 16'h0000, 16'h0000, 16'h0F0F, 1, 16'h00A5, 0);
      add(0, 0, 0, 16'h0000, 16'h0000, 16'h0F0F, 0, 16'h00A5, 0);

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("row%0d", i), tbl[i]);

      // MAR change during a read: Err, then data for the new address
      hs("mchg_rd0", 0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 1, 16'h00A5, 0);
      hs("mchg_rd1", 0, 1, 0, 16'h0020, 16'h0000, 16'hBEEF, 1, 16'h00A5, 1);
      hs("mchg_rd2", 0, 1, 0, 16'h0020, 16'h0000, 16'hBEEF, 1, 16'h00A5, 0);
      hs("mchg_rd3", 0, 0, 0, 16'h0020, 16'h0000, 16'hBEEF, 0, 16'h00A5, 0);

      // MAR change during a write: restart lands on the new address only
      hs("mchg_wr0", 0, 0, 1, 16'h0030, 16'h5555, 16'hBEEF, 0, 16'h00A5, 0);
      hs("mchg_wr1", 0, 0, 1, 16'h0040, 16'h5555, 16'hBEEF, 0, 16'h00A5, 1);
      hs("mchg_wr2", 0, 0, 1, 16'h0040, 16'h5555, 16'hBEEF, 1, 16'h00A5, 0);
      hs("mchg_wr3", 0, 0, 1, 16'h0040, 16'h5555, 16'hBEEF, 0, 16'h00A5, 0);
      hs("mchg_wr4", 0, 0, 0, 16'h0040, 16'h0000, 16'hBEEF, 0, 16'h00A5, 0);
      hs("mchg_wr5", 0, 1, 0, 16'h0030, 16'h0000, 16'hC3C3, 1, 16'h00A5, 0);
      hs("mchg_wr6", 0, 0, 0, 16'h0030, 16'h0000, 16'hC3C3, 0, 16'h00A5, 0);
      hs("mchg_wr7", 0, 1, 0, 16'h0040, 16'h0000, 16'h5555, 1, 16'h00A5, 0);
      hs("mchg_wr8", 0, 0, 0, 16'h0040, 16'h0000, 16'h5555, 0, 16'h00A5, 0);

      // Reset on the would-be commit edge
      hs("rst_wr0", 0, 0, 1, 16'h0010, 16'hAAAA, 16'h5555, 0, 16'h00A5, 0);
      hs("rst_wr1", 0, 0, 1, 16'h0010, 16'hAAAA, 16'h5555, 1, 16'h00A5, 0);
      hs("rst_wr2", 1, 0, 1, 16'h0010, 16'hAAAA, 16'h0000, 0, 16'h0000, 0);
      hs("rst_wr3", 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      hs("rst_wr4", 0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0000, 0);
      hs("rst_wr5", 0, 0, 0, 16'h0010, 16'h0000, 16'h1234, 0, 16'h0000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Memory-side responder for the LC-3 datapath. It answers the control unit's multi-cycle SRAM accesses (Mem_OE/Mem_WE held across wait-state cycles) using an on-chip word array. It maps address 0xFFFF to switch input on reads and to a hex-display register on writes. It sits between the MAR/MDR datapath registers and on-chip RAM, in place of the external SRAM model.

## Interface
- ADDR_W, 16, address width (MAR width)
- DATA_W, 16, data word width
- DEPTH, 1024, words of backing array; valid addresses 0..DEPTH-1
- READ_LAT, 2, consecutive Mem_OE cycles until read data is valid (legal 2..4)
- WRITE_LAT, 3, consecutive Mem_WE cycles required to commit a write (legal 1..4)
- IO_ADDR, 16'hFFFF, memory-mapped I/O address

Reset Reset, synchronous, active-high; clock Clk.
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- MAR  in  ADDR_W  access address
- Data_to_mem  in  DATA_W  write data (MDR)
- Mem_OE  in  1  read request, held for the access duration
- Mem_WE  in  1  write request, held for the access duration
- Switches  in  DATA_W  value returned for reads of IO_ADDR
- Data_from_mem  out  DATA_W  registered read data
- Mem_Ready  out  1  read data valid, or write committed this cycle
- Hex_out  out  DATA_W  I/O display register
- Err  out  1  one-cycle protocol-error pulse

## Operation
- States: IDLE, RD (counting), RD_HOLD, WR (counting), WR_DONE.
- Cnt counts request cycles inside an access. Addr_q is the address captured on the first request cycle.
- IDLE:
  - Mem_OE=1 and Mem_WE=0 -> RD, Cnt=1, capture Addr_q.
  - Mem_WE=1 and Mem_OE=0 -> WR, Cnt=1, capture Addr_q.
  - Both high -> Err pulse next cycle, stay IDLE, no array or I/O action.
- RD:
  - At the edge ending OE cycle READ_LAT-1, Data_from_mem loads the read value. Read value: Switches if Addr_q==IO_ADDR; array[Addr_q] if Addr_q<DEPTH; else 0.
  - Next state is RD_HOLD.
- RD_HOLD:
  - Mem_Ready=1 and Data_from_mem stays stable while Mem_OE remains high.
  - Mem_OE low -> IDLE.
- WR:
  - If Mem_WE is high for WRITE_LAT consecutive cycles, the commit happens at the edge ending cycle WRITE_LAT. Commit target: Hex_out if Addr_q==IO_ADDR; array[Addr_q] if Addr_q<DEPTH; else discarded.
  - Mem_Ready=1 during cycle WRITE_LAT. Next state is WR_DONE.
- WR_DONE:
  - Holds until Mem_WE drops, then IDLE.
  - Exactly one commit per WE assertion, regardless of how long WE is held.
- Early release:
  - WE low before Cnt reaches WRITE_LAT -> no commit, Err pulse, IDLE.
  - OE low before data is valid -> IDLE, no Err, Data_from_mem unchanged.
- MAR changes (MAR != Addr_q) during RD or WR before completion:
  - Err pulse.
  - Access restarts with Cnt=1 and Addr_q=MAR if the request is still held.
- Opposite request during an access:
  - Mem_WE during RD/RD_HOLD, or Mem_OE during WR/WR_DONE -> Err pulse, return to IDLE, no commit.
- Data_to_mem is sampled at the commit edge, not at request start.

## Timing
- Reset values: Data_from_mem=0, Mem_Ready=0, Hex_out=0, Err=0, state IDLE, Cnt=0.
- Array contents are not reset.
- Reset asserted mid-write prevents the commit, even on the would-be commit edge. Reset has priority.
- Read latency: OE cycles 1..READ_LAT-1 show Mem_Ready=0. Data is valid and Mem_Ready=1 from cycle READ_LAT until OE drops.
- Defaults (READ_LAT=2) match a controller that loads MDR in its 2nd OE cycle.
- Write: a Data_to_mem change before the commit edge wins.
- Read-after-write to the same address returns the new data: the array write happens before the next access's read edge.
- Err is registered and lasts exactly one cycle per violation.
- Mem_Ready is registered, derived from the next state.
- Back-to-back accesses: a request arriving in the first cycle after release starts a new access with no idle gap.

## Test plan
- Read, defaults:
  - Stimulus: preload array[0x0010]=0x1234; MAR=0x0010; OE held 3 cycles.
  - Required: Mem_Ready=0 in cycle 1; Data_from_mem=0x1234 with Mem_Ready=1 in cycles 2-3; IDLE after OE drops.
- Write then read:
  - Stimulus: WE held 3 cycles at MAR=0x0020, Data_to_mem=0xBEEF; then read 0x0020.
  - Required: Mem_Ready pulses in write cycle 3; read returns 0xBEEF.
- I/O:
  - Stimulus: write 0x00A5 to 0xFFFF; Switches=0x5A5A; read 0xFFFF.
  - Required: Hex_out=0x00A5 after commit; read returns 0x5A5A; array is untouched.
- Short write:
  - Stimulus: WE held 2 cycles to 0x0030 (WRITE_LAT=3).
  - Required: Err=1 one cycle; array[0x0030] unchanged.
- Conflicts:
  - OE and WE high together -> Err pulse, no action.
  - MAR change mid-read -> Err pulse, then the data delivered is for the new MAR.
- Reset on commit edge:
  - Stimulus: Reset asserted in write cycle 3.
  - Required: no commit; all outputs return to reset values the next cycle.
- Out-of-range:
  - Read 0x2000 returns 0 with normal handshake.
  - Write 0x2000 completes the handshake; no state changes.
